csa_stream_accum: RTL and testbench
===================================

# csa_stream_accum

Streaming multi-operand adder for the datapath. It takes W-bit operands one per cycle over a valid/ready handshake and keeps a redundant carry-save running total (sum and carry vectors), so each accepted beat costs one 3:2 compression row. On the last operand of a packet it resolves the redundant pair to binary with a chunked carry-propagate pass over several cycles, then presents the result on a valid/ready output. It is the serial counterpart of the team's parallel carry-save operand tree, used where operands arrive over time instead of all at once.

## Interface
- W, 8, operand width
- SUM_W, 16, width of the accumulator and result; must exceed W
- MAX_OPS, 10, maximum operands per packet; reaching it forces end of packet
- CHUNK, 4, bits resolved per RESOLVE cycle; SUM_W % CHUNK == 0
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  W  unsigned operand
- in_last  in  1  beat is the final operand of the packet
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_sum  out  SUM_W  resolved sum
- out_count  out  $clog2(MAX_OPS+1)  operands in the packet
- out_ovf  out  1  true sum did not fit in SUM_W bits (sticky per packet)

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE/ACCUM: in_ready=1. An accepted beat (in_valid&&in_ready) does S,C <= csa(S, C<<1, zext(in_data)) and count++. The bit shifted out of the carry MSB ORs into ovf.
- The first beat in IDLE goes to ACCUM with S=zext(in_data), C=0, count=1, ovf=0.
- Accepted beat with in_last=1, or the beat that makes count==MAX_OPS → RESOLVE, chunk index k=0, carry-in 0.
- RESOLVE: in_ready=0. Each cycle adds chunk k of S and C<<1 plus the carry-in, writes result bits [k*CHUNK +: CHUNK] and registers the chunk carry-out. The final chunk's carry-out ORs into ovf. After chunk SUM_W/CHUNK-1 → DONE.
- DONE: out_valid=1, in_ready=0. out_sum, out_count and out_ovf stay stable until out_ready=1, then → IDLE. in_valid is ignored outside IDLE/ACCUM.
- Result is the sum of all packet operands mod 2^SUM_W (see Configuration).

## Timing
- Reset, asynchronous: state=IDLE, S=C=0, out_sum=0, out_count=0, out_ovf=0, out_valid=0, in_ready=0 while rst_n low. in_ready=1 on the first cycle after deassertion.
- Throughput: one operand per cycle while accumulating.
- Latency: if the last beat is accepted in cycle t, RESOLVE occupies t+1..t+R with R=SUM_W/CHUNK (4 by default), and out_valid=1 from cycle t+1+R.
- When out_ready is sampled high in DONE, the next cycle is IDLE with in_ready=1. Minimum gap between packets is R+2 cycles.
- A single-beat packet is legal and follows the same latency.
- Reset mid-RESOLVE or in DONE discards the packet with no partial output.

## Configuration
- CSA_ACC_SAT_EN defined: when out_ovf=1, out_sum is forced to all ones (2^SUM_W-1).
- Not defined: out_sum is the wrapped value. out_ovf is still reported.

## Structure
- Package csa_acc_pkg holds the state enum (IDLE, ACCUM, RESOLVE, DONE) and the count-width helper function.
- Sub-module csa_row: a parameterised N-bit 3:2 compressor with S = a^b^c and CO = majority(a,b,c), instantiated once at width SUM_W.
- The chunk adder is inline RTL.

## Test plan
- 10 beats 11,2,13,4,5,6,7,8,9,10, in_last on the 10th → out_sum=75, out_count=10, out_ovf=0, out_valid exactly 5 cycles after the last accept.
- Back-to-back packets 3,14,5,6,7,8,19,10,0,0 then 255 (single beat, last) → results 72 (count 10) then 255 (count 1), in that order.
- 12 beats of 255 with no in_last, then in_last on the 12th → first result 2550 (count 10, forced by MAX_OPS); second packet 510 (count 2).
- out_ready held low 3 cycles in DONE → out_sum/out_count stable, in_ready=0 for all 3 cycles, then IDLE.
- SUM_W=8, CHUNK=4: beats 200 then 100 (last) → out_ovf=1 and out_sum=255 with CSA_ACC_SAT_EN, out_sum=44 without.
- rst_n pulsed low during the 2nd RESOLVE cycle → all outputs 0 immediately, no out_valid. The next packet 1,2 (last) gives 3.

Source files
------------

// File: rtl/csa_stream_accum_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Operand counter must hold the value MAX_OPS itself.
  function automatic int cnt_width(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction

endpackage

// File: rtl/csa_stream_accum_if.sv
// Operand and result handshake bundle of the carry-save stream accumulator.
interface csa_stream_accum_if #(
  parameter int W       = 8,
  parameter int SUM_W   = 16,
  parameter int MAX_OPS = 10
);
  localparam int CNT_W = csa_acc_pkg::cnt_width(MAX_OPS);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/csa_stream_accum_row.sv
// One row of 3:2 compressors: bitwise full adders without carry propagation.
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_c,
  output logic [N-1:0] o_s,
  output logic [N-1:0] o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/csa_stream_accum.sv
// Streaming multi-operand adder: carry-save accumulation, chunked final resolve.
// Optional macro CSA_ACC_SAT_EN saturates out_sum to all ones on overflow.
module csa_stream_accum
  import csa_acc_pkg::*;
#(
  parameter int W       = 8,
  parameter int SUM_W   = 16,
  parameter int MAX_OPS = 10,
  parameter int CHUNK   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_stream_accum_if.slave bus
);

  localparam int CNT_W  = cnt_width(MAX_OPS);
  localparam int NCHUNK = SUM_W / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [SUM_W-1:0] r_s;
  logic [SUM_W-1:0] r_c;
  logic [SUM_W-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_cin;
  logic [KW-1:0]    r_k;

  logic [W-1:0]     w_data;
  logic [SUM_W-1:0] w_ext;
  logic [SUM_W-1:0] w_c_sh;
  logic [SUM_W-1:0] w_row_s;
  logic [SUM_W-1:0] w_row_c;
  logic             w_in_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_end;
  logic             w_last_chunk;
  int               w_base;
  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic [CHUNK:0]   w_chunk_sum;

  assign w_data       = bus.in_data;
  assign w_ext        = SUM_W'(w_data);
  assign w_c_sh       = r_c << 1;
  // Gated by rst_n so the input side looks closed for the whole reset pulse.
  assign w_in_ready   = rst_n && ((r_state == IDLE) || (r_state == ACCUM));
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_cnt_next   = (r_state == IDLE) ? CNT_W'(1) : (r_cnt + CNT_W'(1));
  assign w_end        = bus.in_last || (w_cnt_next == CNT_W'(MAX_OPS));
  assign w_last_chunk = (r_k == KW'(NCHUNK - 1));

  csa_row #(.N(SUM_W)) u_row (
    .i_a  (r_s),
    .i_b  (w_c_sh),
    .i_c  (w_ext),
    .o_s  (w_row_s),
    .o_co (w_row_c)
  );

  always_comb begin
    w_base      = int'(r_k) * CHUNK;
    w_chunk_a   = r_s[w_base +: CHUNK];
    w_chunk_b   = w_c_sh[w_base +: CHUNK];
    w_chunk_sum = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{CHUNK{1'b0}}, r_cin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_next = w_end ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        if (w_last_chunk) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Overflow is exact: a carry MSB dropped by C<<1 or a final chunk carry both mean >= 2^SUM_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_c   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_cin <= 1'b0;
      r_k   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s   <= w_ext;
            r_c   <= '0;
            r_cnt <= CNT_W'(1);
            r_ovf <= 1'b0;
            r_cin <= 1'b0;
            r_k   <= '0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_s   <= w_row_s;
            r_c   <= w_row_c;
            r_cnt <= w_cnt_next;
            r_ovf <= r_ovf | r_c[SUM_W-1];
            r_cin <= 1'b0;
            r_k   <= '0;
          end
        end
        RESOLVE: begin
          r_res[w_base +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
          r_cin                  <= w_chunk_sum[CHUNK];
          if (w_last_chunk) begin
            r_k   <= '0;
            r_ovf <= r_ovf | w_chunk_sum[CHUNK] | r_c[SUM_W-1];
          end else begin
            r_k   <= r_k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_count = r_cnt;
  assign bus.out_ovf   = r_ovf;

`ifdef CSA_ACC_SAT_EN
  assign bus.out_sum = r_ovf ? {SUM_W{1'b1}} : r_res;
`else
  assign bus.out_sum = r_res;
`endif

endmodule

// File: tb/tb_csa_stream_accum.sv
// Directed bench for csa_stream_accum: a 16-bit instance plus an 8-bit one for overflow.
module tb_csa_stream_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  csa_stream_accum_if #(.W(8), .SUM_W(16), .MAX_OPS(10)) bus ();
  csa_stream_accum_if #(.W(8), .SUM_W(8),  .MAX_OPS(10)) bus8 ();

  csa_stream_accum #(.W(8), .SUM_W(16), .MAX_OPS(10), .CHUNK(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  csa_stream_accum #(.W(8), .SUM_W(8), .MAX_OPS(10), .CHUNK(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Holds one beat until it is accepted; returns on the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", 32'(n < 64), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitResult(output int cyc);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic checkResult(input string tag, input int s, input int c, input int o);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_sum"},   32'(bus.out_sum),   32'(s));
    checkOutput({tag, "_count"}, 32'(bus.out_count), 32'(c));
    checkOutput({tag, "_ovf"},   32'(bus.out_ovf),   32'(o));
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int n8;
    int exp8;
    logic seen;
    int t1[10]  = '{11, 2, 13, 4, 5, 6, 7, 8, 9, 10};
    int t2[10]  = '{3, 14, 5, 6, 7, 8, 19, 10, 0, 0};

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.in_last   = 1'b0;
    bus8.out_ready = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_sum",   32'(bus.out_sum),   32'd0);
    checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
    checkOutput("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // 8-bit accumulator overflow: 200 + 100 = 300
`ifdef CSA_ACC_SAT_EN
    exp8 = 255;
`else
    exp8 = 44;
`endif
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'd200;
    bus8.in_last  = 1'b0;
    @(negedge clk);
    bus8.in_data  = 8'd100;
    bus8.in_last  = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    n8 = 0;
    while (bus8.out_valid !== 1'b1 && n8 < 64) begin
      @(negedge clk);
      n8++;
    end
    checkOutput("ovf8_valid", 32'(bus8.out_valid), 32'd1);
    checkOutput("ovf8_sum",   32'(bus8.out_sum),   32'(exp8));
    checkOutput("ovf8_count", 32'(bus8.out_count), 32'd2);
    checkOutput("ovf8_ovf",   32'(bus8.out_ovf),   32'd1);
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;

    // Ten beats with in_last on the tenth, latency and stall in DONE
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'(t1[i]), (i == 9));
    end
    waitResult(cyc);
    checkOutput("t1_latency", 32'(cyc), 32'd5);
    checkResult("t1", 75, 10, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_sum",       32'(bus.out_sum),   32'd75);
      checkOutput("hold_count",     32'(bus.out_count), 32'd10);
      checkOutput("hold_in_ready",  32'(bus.in_ready),  32'd0);
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    consume();
    checkOutput("hold_idle_ready", 32'(bus.in_ready),  32'd1);
    checkOutput("hold_idle_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back: packet closed by MAX_OPS, then a single-beat packet
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'(t2[i]), 1'b0);
    end
    waitResult(cyc);
    checkOutput("t2a_latency", 32'(cyc), 32'd5);
    checkResult("t2a", 72, 10, 0);
    consume();
    applyStimulus(8'd255, 1'b1);
    waitResult(cyc);
    checkOutput("t2b_latency", 32'(cyc), 32'd5);
    checkResult("t2b", 255, 1, 0);
    consume();

    // Twelve beats of 255: forced split after ten
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'd255, 1'b0);
    end
    waitResult(cyc);
    checkResult("t3a", 2550, 10, 0);
    consume();
    applyStimulus(8'd255, 1'b0);
    applyStimulus(8'd255, 1'b1);
    waitResult(cyc);
    checkResult("t3b", 510, 2, 0);
    consume();

    // Reset during the second RESOLVE cycle discards the packet
    applyStimulus(8'd50, 1'b0);
    applyStimulus(8'd60, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_out_sum",   32'(bus.out_sum),   32'd0);
    checkOutput("midrst_out_count", 32'(bus.out_count), 32'd0);
    checkOutput("midrst_out_ovf",   32'(bus.out_ovf),   32'd0);
    checkOutput("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    checkOutput("midrst_no_valid", 32'(seen), 32'd0);
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd2, 1'b1);
    waitResult(cyc);
    checkOutput("t6_latency", 32'(cyc), 32'd5);
    checkResult("t6", 3, 2, 0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
